// File: rtl/instr_fetch.sv
// Instruction fetch unit: pulls one or two bytes per instruction over a req/ack
// byte port, holds the 16-bit word until the decoder accepts it, then steers the PC.
module instr_fetch #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_rdata,
  input  logic              imem_ack,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic [1:0]        pc_src,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] ra_target,
  input  logic [ADDR_W-1:0] jal_target,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_seq,
  output logic              halted,
  output logic [15:0]       instr_count
);

  typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, VALID, HALT} state_t;

  state_t state, state_nxt;
  logic   accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // imem_ack only matters in the two fetch states, so stray acks fall through.
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      IDLE:   state_nxt = FETCH0;
      FETCH0: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = (imem_rdata[7:6] == 2'b11) ? FETCH1 : VALID;
      end
      FETCH1: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = VALID;
      end
      VALID: begin
        instr_valid = 1'b1;
        if (instr_ready) state_nxt = halt ? HALT : FETCH0;
      end
      HALT:    halted = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = instr_valid & instr_ready;
  assign imem_addr = (state == FETCH1) ? pc + ADDR_W'(1) : pc;
  assign pc_seq    = pc + ((instr[7:6] == 2'b11) ? ADDR_W'(2) : ADDR_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      instr       <= 16'h0000;
      instr_count <= 16'h0000;
    end else begin
      if (state == FETCH0 && imem_ack) instr <= {8'h00, imem_rdata};
      if (state == FETCH1 && imem_ack) instr[15:8] <= imem_rdata;
      if (accept) begin
        instr_count <= instr_count + 16'd1;
        case (pc_src)
          2'b00: pc <= pc_seq;
          2'b01: pc <= br_target;
          2'b10: pc <= ra_target;
          2'b11: pc <= jal_target;
          default: pc <= pc_seq;
        endcase
      end
    end
  end

endmodule
